// File: rtl/mips16_fetch_stage_pkg.sv
// Shared constants, types and helpers for the 16-bit MIPS instruction fetch stage.
// The opcode field is bits [15:12]; fetch halts when it equals HALT_OPCODE.
package mips16_fetch_stage_pkg;

  localparam int XLEN = 16;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t      RESET_PC    = 16'h0000;
  localparam logic [3:0] HALT_OPCODE = 4'hF;
  localparam word_t      NOP_INSTR   = 16'h0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  function automatic logic is_halt(input word_t instr);
    return instr[15:12] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/mips16_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats capture/retire.
// retire drops valid without touching the payload (HALT instruction consumed).
module if_id_reg
  import mips16_fetch_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              flush,
  input  logic              capture,
  input  logic              retire,
  input  logic [XLEN-1:0]   next_instr,
  input  logic [XLEN-1:0]   next_pc,
  input  logic [XLEN-1:0]   next_pc_inc,
  output logic              valid,
  output logic [XLEN-1:0]   instr,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_inc
);

  // NOTE: every flop here gets a reset value; decode reads these fields directly,
  // so they must never be X after reset even while valid is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid  <= 1'b0;
      instr  <= NOP_INSTR;
      pc     <= '0;
      pc_inc <= '0;
    end else if (flush) begin
      // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (!hold) begin
      if (capture) begin
        valid  <= 1'b1;
        instr  <= next_instr;
        pc     <= next_pc;
        pc_inc <= next_pc_inc;
      end else if (retire) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mips16_fetch_stage.sv
// IF stage: PC register, next-PC selection and BOOT/RUN/HALT control.
// Drives instruction memory combinationally from pc and fills the IF/ID register.
module mips16_fetch_stage
  import mips16_fetch_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [XLEN-1:0]   imem_data,
  input  logic              id_ready,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic [XLEN-1:0]   pc,
  output logic              if_id_valid,
  output logic [XLEN-1:0]   if_id_instr,
  output logic [XLEN-1:0]   if_id_pc,
  output logic [XLEN-1:0]   if_id_pc_inc,
  output logic              halted
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        pc_plus1;
  logic         halted_q, halted_d;
  logic         advance, capture, retire, flush, hold;

  assign pc_plus1  = pc_q + 16'd1;
  assign advance   = !if_id_valid || id_ready;
  assign hold      = !advance;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign halted    = halted_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    capture  = 1'b0;
    retire   = 1'b0;
    flush    = 1'b0;
    if (redirect) begin
      // Redirect wins over stall: the stalled IF/ID entry is dead anyway.
      pc_d     = redirect_pc;
      flush    = 1'b1;
      halted_d = 1'b0;
      state_d  = ST_RUN;
    end else begin
      unique case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN: begin
          if (advance) begin
            capture = 1'b1;
            if (is_halt(imem_data)) begin
              halted_d = 1'b1;
              state_d  = ST_HALT;
            end else begin
              pc_d = pc_plus1;
            end
          end
        end
        ST_HALT: retire = id_ready;
        default: state_d = ST_BOOT;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk         (clk),
    .reset       (reset),
    .hold        (hold),
    .flush       (flush),
    .capture     (capture),
    .retire      (retire),
    .next_instr  (imem_data),
    .next_pc     (pc_q),
    .next_pc_inc (pc_plus1),
    .valid       (if_id_valid),
    .instr       (if_id_instr),
    .pc          (if_id_pc),
    .pc_inc      (if_id_pc_inc)
  );

endmodule
